// File: rtl/hdmi_ddr_serializer_ctrl.sv
// TMDS serializer front end: turns 10-bit symbols for three data channels plus
// the clock channel into 2-bit DDR pos/neg pairs on the 5x pixel clock.
module hdmi_ddr_serializer_ctrl #(
  parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100,
  parameter logic [9:0] CLK_PATTERN = 10'b0000011111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] in_sym0,
  input  logic [9:0] in_sym1,
  input  logic [9:0] in_sym2,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] pos0,
  output logic [1:0] neg0,
  output logic [1:0] pos1,
  output logic [1:0] neg1,
  output logic [1:0] pos2,
  output logic [1:0] neg2,
  output logic [1:0] posc,
  output logic [1:0] negc,
  output logic       pixel_strobe,
  output logic       underflow,
  output logic       underflow_sticky,
  input  logic       clear_sticky
);

  logic [2:0]  phase;
  logic [9:0]  sr0, sr1, sr2, src;
  logic [29:0] hold_buf;
  logic        buf_full;
  logic        load_cycle;
  logic        xfer;
  logic        starve;

  assign load_cycle = (phase == 3'd4);
  assign in_ready   = !buf_full || load_cycle;
  assign xfer       = in_valid && in_ready;
  assign starve     = load_cycle && !buf_full && !xfer;

  assign pos0 = sr0[1:0];
  assign neg0 = ~sr0[1:0];
  assign pos1 = sr1[1:0];
  assign neg1 = ~sr1[1:0];
  assign pos2 = sr2[1:0];
  assign neg2 = ~sr2[1:0];
  assign posc = src[1:0];
  assign negc = ~src[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      phase            <= 3'd0;
      sr0              <= IDLE_SYMBOL;
      sr1              <= IDLE_SYMBOL;
      sr2              <= IDLE_SYMBOL;
      src              <= CLK_PATTERN;
      hold_buf         <= '0;
      buf_full         <= 1'b0;
      pixel_strobe     <= 1'b0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      phase        <= load_cycle ? 3'd0 : phase + 3'd1;
      // registered so the strobe is high exactly while phase 4 is current
      pixel_strobe <= (phase == 3'd3);
      underflow    <= starve;

      if (load_cycle) begin
        src <= CLK_PATTERN;
        if (buf_full) begin
          {sr2, sr1, sr0} <= hold_buf;
        end else if (xfer) begin
          {sr2, sr1, sr0} <= {in_sym2, in_sym1, in_sym0};
        end else begin
          sr0 <= IDLE_SYMBOL;
          sr1 <= IDLE_SYMBOL;
          sr2 <= IDLE_SYMBOL;
        end
        // a full buffer is refilled in the same cycle it drains
        if (buf_full && xfer) begin
          hold_buf <= {in_sym2, in_sym1, in_sym0};
        end else if (buf_full) begin
          buf_full <= 1'b0;
        end
      end else begin
        sr0 <= {2'b00, sr0[9:2]};
        sr1 <= {2'b00, sr1[9:2]};
        sr2 <= {2'b00, sr2[9:2]};
        src <= {2'b00, src[9:2]};
        if (xfer) begin
          hold_buf <= {in_sym2, in_sym1, in_sym0};
          buf_full <= 1'b1;
        end
      end

      // set wins over clear, both on the starved load and while the pulse is visible
      if (starve || underflow) begin
        underflow_sticky <= 1'b1;
      end else if (clear_sticky) begin
        underflow_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_ddr_serializer_ctrl.sv
// Directed bench for hdmi_ddr_serializer_ctrl: idle/clock patterns, buffered,
// bypass and backpressured handshakes, reset abort and sticky flag handling.
module tb_hdmi_ddr_serializer_ctrl;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [1:0] IDLE_P [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
  localparam logic [1:0] CLK_P  [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] in_sym0, in_sym1, in_sym2;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] pos0, neg0, pos1, neg1, pos2, neg2, posc, negc;
  logic       pixel_strobe, underflow, underflow_sticky, clear_sticky;

  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;

  hdmi_ddr_serializer_ctrl dut (
    .clock(clock), .reset(reset),
    .in_sym0(in_sym0), .in_sym1(in_sym1), .in_sym2(in_sym2),
    .in_valid(in_valid), .in_ready(in_ready),
    .pos0(pos0), .neg0(neg0), .pos1(pos1), .neg1(neg1),
    .pos2(pos2), .neg2(neg2), .posc(posc), .negc(negc),
    .pixel_strobe(pixel_strobe), .underflow(underflow),
    .underflow_sticky(underflow_sticky), .clear_sticky(clear_sticky)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock; samples land on the falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    ph = (ph == 4) ? 0 : ph + 1;
    check_val("strobe", {31'd0, pixel_strobe}, {31'd0, ph == 4});
  endtask

  function automatic logic [29:0] trip(input int k);
    logic [9:0] a, b, c;
    a = 10'(k * 37 + 5);
    b = 10'(k * 91 + 3);
    c = ~a;
    return {c, b, a};
  endfunction

  logic [29:0] q[$];
  logic [29:0] cur;
  logic [1:0]  e2;
  logic        xf, was4;
  int          k;

  initial begin
    reset = 1'b1; in_valid = 1'b0; clear_sticky = 1'b0;
    in_sym0 = '0; in_sym1 = '0; in_sym2 = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ph = 0;

    check_val("rst_strobe", {31'd0, pixel_strobe}, 0);
    check_val("rst_uflow", {31'd0, underflow}, 0);
    check_val("rst_sticky", {31'd0, underflow_sticky}, 0);
    check_val("rst_ready", {31'd0, in_ready}, 1);
    check_val("rst_pos1", pos1, 2'b00);
    check_val("rst_pos2", pos2, 2'b00);

    // first symbol after reset: idle on data channels, clock pattern on clock channel
    for (int i = 0; i < 5; i++) begin
      check_val("idle_pos0", pos0, IDLE_P[i]);
      e2 = ~IDLE_P[i];
      check_val("idle_neg0", neg0, e2);
      check_val("rst_posc", posc, CLK_P[i]);
      if (i < 4) tick();
    end

    // starved load: underflow pulse, sticky set; clock window after strobe
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        check_val("uf_pulse", {31'd0, underflow}, 1);
        check_val("uf_sticky", {31'd0, underflow_sticky}, 1);
        check_val("uf_pos0", pos0, 2'b00);
      end
      if (i == 1) check_val("uf_once", {31'd0, underflow}, 0);
      check_val("clk_posc", posc, CLK_P[i]);
      e2 = ~CLK_P[i];
      check_val("clk_negc", negc, e2);
      if (i < 4) tick();
    end

    // buffered path: handshake at phase 1
    tick();
    tick();
    in_sym0 = 10'h3FF; in_sym1 = 10'h000; in_sym2 = 10'h155; in_valid = 1'b1;
    check_val("buf_ready_p1", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    in_sym0 = 10'h0AA; in_sym1 = 10'h2C1; in_sym2 = 10'h01E;
    check_val("buf_ready_p2", {31'd0, in_ready}, 0);
    tick();
    check_val("buf_ready_p3", {31'd0, in_ready}, 0);
    tick();
    check_val("buf_ready_p4", {31'd0, in_ready}, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        check_val("buf_uflow", {31'd0, underflow}, 0);
        check_val("buf_drained", {31'd0, in_ready}, 1);
      end
      check_val("buf_pos0", pos0, 2'b11);
      check_val("buf_pos1", pos1, 2'b00);
      check_val("buf_pos2", pos2, 2'b01);
      if (i < 4) tick();
    end

    // bypass path: valid first seen at phase 4 with an empty buffer
    in_sym0 = 10'h272; in_sym1 = 10'h3C3; in_sym2 = 10'h001; in_valid = 1'b1;
    check_val("byp_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    check_val("byp_pos0", pos0, 2'b10);
    check_val("byp_pos1", pos1, 2'b11);
    check_val("byp_pos2", pos2, 2'b01);
    check_val("byp_uflow", {31'd0, underflow}, 0);
    check_val("byp_empty", {31'd0, in_ready}, 1);
    tick();
    check_val("byp_pos0_b", pos0, 2'b00);
    cur = {10'h001, 10'h3C3, 10'h272};

    // backpressure: valid held high from phase 1
    k = 0;
    {in_sym2, in_sym1, in_sym0} = trip(0);
    in_valid = 1'b1;
    for (int c = 0; c < 21; c++) begin
      check_val("bp_ready", {31'd0, in_ready}, {31'd0, (c == 0) || (ph == 4)});
      check_val("bp_pos0", pos0, cur[2*ph +: 2]);
      check_val("bp_pos1", pos1, cur[10 + 2*ph +: 2]);
      check_val("bp_pos2", pos2, cur[20 + 2*ph +: 2]);
      check_val("bp_uflow", {31'd0, underflow}, 0);
      xf = in_valid && in_ready;
      if (xf) begin
        q.push_back(trip(k));
        k++;
      end
      was4 = (ph == 4);
      tick();
      if (was4) cur = (q.size() > 0) ? q.pop_front() : {IDLE, IDLE, IDLE};
      if (xf) {in_sym2, in_sym1, in_sym0} = trip(k);
    end
    in_valid = 1'b0;
    check_val("bp_count", k, 5);

    // reset at phase 2 with a full buffer discards it
    check_val("rst2_full", {31'd0, in_ready}, 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ph = 0;
    check_val("rst2_pos0", pos0, 2'b00);
    check_val("rst2_pos1", pos1, 2'b00);
    check_val("rst2_posc", posc, 2'b11);
    check_val("rst2_ready", {31'd0, in_ready}, 1);
    check_val("rst2_strobe", {31'd0, pixel_strobe}, 0);
    check_val("rst2_sticky", {31'd0, underflow_sticky}, 0);
    repeat (5) tick();
    check_val("rst2_discard_uf", {31'd0, underflow}, 1);
    check_val("rst2_discard_pos0", pos0, 2'b00);
    check_val("rst2_sticky_set", {31'd0, underflow_sticky}, 1);

    // clear coincident with the visible underflow pulse: set wins
    clear_sticky = 1'b1;
    tick();
    check_val("clr_vs_pulse", {31'd0, underflow_sticky}, 1);
    tick();
    check_val("clr_plain", {31'd0, underflow_sticky}, 0);
    clear_sticky = 1'b0;
    tick();
    tick();
    // clear coincident with the starved load cycle: set wins
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    check_val("clr_vs_load_uf", {31'd0, underflow}, 1);
    check_val("clr_vs_load", {31'd0, underflow_sticky}, 1);
    tick();
    check_val("clr_vs_load_hold", {31'd0, underflow_sticky}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
